// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states and the result-flag bundle.
package alu_defs;

   localparam int         DATA_W       = 16;
   localparam logic [4:0] ALU_OP_ADD   = 5'b00001;
   // NOP is an ADD whose result is simply not consumed.
   localparam logic [4:0] ALU_OP_NOP   = ALU_OP_ADD;
   localparam logic [4:0] MUL_LAST_CNT = 5'd15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      MUL    = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic overflow;
      logic less;
      logic equal;
      logic greater;
      logic zero;
   } res_flags_t;

   function automatic res_flags_t mul_flags(input logic [DATA_W-1:0] acc, input logic ovf);
      res_flags_t f;
      f          = '0;
      f.overflow = ovf;
      f.zero     = (acc == '0);
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_datapath.sv
// Shift-add multiplier state: accumulator, shifting multiplicand/multiplier, overflow tracking
// and iteration count. The external ALU performs every accumulate.
module alu_mul_datapath
   import alu_defs::*;
#(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic [DATA_W-1:0] load_a,
   input  logic [DATA_W-1:0] load_b,
   input  logic [DATA_W-1:0] alu_q,
   input  logic              alu_overflow,
   output logic              add_now,
   output logic [DATA_W-1:0] acc,
   output logic [DATA_W-1:0] mcand,
   output logic [DATA_W-1:0] acc_nxt,
   output logic              ovf_nxt,
   output logic              last
);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplr_q, mplr_d;
   logic              lost_q, lost_d;
   logic              ovf_q, ovf_d;
   logic [4:0]        cnt_q, cnt_d;

   assign add_now = mplr_q[0];
   assign acc     = acc_q;
   assign mcand   = mcand_q;

   // A previously shifted-out multiplicand bit means any further add overflows the true product.
   assign acc_nxt = add_now ? alu_q : acc_q;
   assign ovf_nxt = add_now ? (ovf_q | alu_overflow | lost_q) : ovf_q;

   assign last = (cnt_q == MUL_LAST_CNT) || (EARLY_EXIT && (mplr_q[DATA_W-1:1] == '0));

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      lost_d  = lost_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (start) begin
         acc_d   = '0;
         mcand_d = load_a;
         mplr_d  = load_b;
         lost_d  = 1'b0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else if (step) begin
         acc_d   = acc_nxt;
         ovf_d   = ovf_nxt;
         lost_d  = lost_q | mcand_q[DATA_W-1];
         mcand_d = mcand_q << 1;
         mplr_d  = mplr_q >> 1;
         cnt_d   = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         lost_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         lost_q  <= lost_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Owns the ALU A/B/op inputs: runs single ALU ops or a shift-add 16x16 multiply and
// returns a registered result with flags over valid/ready handshakes.
module alu_sequencer
   import alu_defs::*;
#(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_mul,
   input  logic [4:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_op,
   input  logic [15:0] alu_q,
   input  logic        alu_overflow,
   input  logic        alu_less,
   input  logic        alu_equal,
   input  logic        alu_greater,
   input  logic        alu_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_q,
   output logic        res_overflow,
   output logic        res_less,
   output logic        res_equal,
   output logic        res_greater,
   output logic        res_zero,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // req_ready is high only in IDLE; res_valid is high only in DONE and res_* hold until taken.

   seq_state_t        state_q, state_d;
   logic [15:0]       a_q, a_d;
   logic [15:0]       b_q, b_d;
   logic [4:0]        op_q, op_d;
   logic [15:0]       res_data_q, res_data_d;
   res_flags_t        res_flags_q, res_flags_d;

   logic              mul_start;
   logic              mul_step;
   logic              mul_add_now;
   logic [15:0]       mul_acc;
   logic [15:0]       mul_mcand;
   logic [15:0]       mul_acc_nxt;
   logic              mul_ovf_nxt;
   logic              mul_last;

   alu_mul_datapath #(
      .EARLY_EXIT (EARLY_EXIT)
   ) u_mul (
      .clk          (clk),
      .reset        (reset),
      .start        (mul_start),
      .step         (mul_step),
      .load_a       (req_a),
      .load_b       (req_b),
      .alu_q        (alu_q),
      .alu_overflow (alu_overflow),
      .add_now      (mul_add_now),
      .acc          (mul_acc),
      .mcand        (mul_mcand),
      .acc_nxt      (mul_acc_nxt),
      .ovf_nxt      (mul_ovf_nxt),
      .last         (mul_last)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      res_data_d  = res_data_q;
      res_flags_d = res_flags_q;
      mul_start   = 1'b0;
      mul_step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d  = req_a;
               b_d  = req_b;
               op_d = req_op;
               if (req_mul) begin
                  mul_start = 1'b1;
                  state_d   = MUL;
               end else begin
                  state_d   = SINGLE;
               end
            end
         end
         SINGLE: begin
            res_data_d           = alu_q;
            res_flags_d.overflow = alu_overflow;
            res_flags_d.less     = alu_less;
            res_flags_d.equal    = alu_equal;
            res_flags_d.greater  = alu_greater;
            res_flags_d.zero     = alu_zero;
            state_d              = DONE;
         end
         MUL: begin
            mul_step = 1'b1;
            if (mul_last) begin
               res_data_d  = mul_acc_nxt;
               res_flags_d = mul_flags(mul_acc_nxt, mul_ovf_nxt);
               state_d     = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ALU inputs are a registered-source mux; nothing from req_* reaches the ALU directly.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_OP_NOP;
      case (state_q)
         SINGLE: begin
            alu_a  = a_q;
            alu_b  = b_q;
            alu_op = op_q;
         end
         MUL: begin
            alu_a  = mul_acc;
            alu_b  = mul_mcand;
            alu_op = mul_add_now ? ALU_OP_ADD : ALU_OP_NOP;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= ALU_OP_NOP;
         res_data_q  <= '0;
         res_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         res_data_q  <= res_data_d;
         res_flags_q <= res_flags_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign res_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign dbg_state    = state_q;
   assign res_q        = res_data_q;
   assign res_overflow = res_flags_q.overflow;
   assign res_less     = res_flags_q.less;
   assign res_equal    = res_flags_q.equal;
   assign res_greater  = res_flags_q.greater;
   assign res_zero     = res_flags_q.zero;

endmodule
